btn_repeat_gen: RTL and testbench

//   Consumer side of the button input path. Takes the clean, synchronised button

---
 rtl/btn_repeat_gen_pkg.sv | 24 ++
 rtl/btn_repeat_chan.sv | 112 +++++++++++
 rtl/btn_repeat_gen.sv | 41 ++++
 tb/tb_btn_repeat_gen.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_repeat_gen_pkg.sv
// Shared button-path definitions: channel state encodings,
// default timing constants and the counter width helper.
package btn_repeat_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  localparam int DEF_PIN_NUM       = 3;
  localparam int DEF_DELAY_CYCLES  = 12_500_000;
  localparam int DEF_REPEAT_CYCLES = 2_500_000;

  function automatic int cnt_width(
    input int dly,
    input int rep
  );
    int m;
    m = (dly > rep) ? dly : rep;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/btn_repeat_chan.sv
// One button channel: press edge, delay/repeat FSM, counter.
// BTN_RELEASE_PULSE_EN adds a registered release_pulse output.
module btn_repeat_chan
  import btn_repeat_gen_pkg::*;
#(
  parameter int DELAY_CYCLES  = DEF_DELAY_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = cnt_width(DELAY_CYCLES, REPEAT_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  input  logic repeat_en,
`ifdef BTN_RELEASE_PULSE_EN
  output logic release_pulse,
`endif
  output logic press_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] DLY_END = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_END = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_prev;
  logic             r_pulse;
  logic             r_held;
  logic             w_edge;

`ifdef BTN_RELEASE_PULSE_EN
  logic r_rel;
  assign release_pulse = r_rel;
`endif

  assign w_edge      = pin_in & ~r_prev;
  assign press_pulse = r_pulse;
  assign held        = r_held;

  // prev resets high so a button held through reset is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_prev  <= 1'b1;
      r_pulse <= 1'b0;
      r_held  <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
      r_rel   <= 1'b0;
`endif
    end else begin
      r_prev  <= pin_in;
      r_pulse <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
      r_rel   <= 1'b0;
`endif
      unique case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            r_state <= ST_DELAY;
            r_cnt   <= '0;
            r_pulse <= 1'b1;
            r_held  <= 1'b1;
          end
        end
        ST_DELAY: begin
          if (!pin_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
            r_rel   <= 1'b1;
`endif
          end else if (r_cnt == DLY_END) begin
            if (repeat_en) begin
              r_state <= ST_REPEAT;
              r_cnt   <= '0;
              r_pulse <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (!pin_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
            r_rel   <= 1'b1;
`endif
          end else if (!repeat_en) begin
            // parked at delay terminal: re-enable fires next cycle
            r_state <= ST_DELAY;
            r_cnt   <= DLY_END;
          end else if (r_cnt == REP_END) begin
            r_cnt   <= '0;
            r_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_repeat_gen.sv
// Button press/auto-repeat event generator, one channel per pin.
// BTN_RELEASE_PULSE_EN adds the release_pulse output.
module btn_repeat_gen
  import btn_repeat_gen_pkg::*;
#(
  parameter int PIN_NUM       = DEF_PIN_NUM,
  parameter int DELAY_CYCLES  = DEF_DELAY_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIN_NUM-1:0] pin_in,
  input  logic [PIN_NUM-1:0] repeat_en,
`ifdef BTN_RELEASE_PULSE_EN
  output logic [PIN_NUM-1:0] release_pulse,
`endif
  output logic [PIN_NUM-1:0] press_pulse,
  output logic [PIN_NUM-1:0] held
);

  localparam int CNT_W = cnt_width(DELAY_CYCLES, REPEAT_CYCLES);

  for (genvar g = 0; g < PIN_NUM; g++) begin : g_chan
    btn_repeat_chan #(
      .DELAY_CYCLES  (DELAY_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .CNT_W         (CNT_W)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .pin_in        (pin_in[g]),
      .repeat_en     (repeat_en[g]),
`ifdef BTN_RELEASE_PULSE_EN
      .release_pulse (release_pulse[g]),
`endif
      .press_pulse   (press_pulse[g]),
      .held          (held[g])
    );
  end

endmodule

// File: tb/tb_btn_repeat_gen.sv
// Directed bench for btn_repeat_gen (DELAY=10, REPEAT=4, 3 pins).
// BTN_RELEASE_PULSE_EN enables the release pulse scenario.
module tb_btn_repeat_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] pin_in;
  logic [2:0] repeat_en;
  logic [2:0] press_pulse;
  logic [2:0] held;
`ifdef BTN_RELEASE_PULSE_EN
  logic [2:0] release_pulse;
`endif

  int checks = 0;
  int errors = 0;

  btn_repeat_gen #(
    .PIN_NUM       (3),
    .DELAY_CYCLES  (10),
    .REPEAT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pin_in        (pin_in),
    .repeat_en     (repeat_en),
`ifdef BTN_RELEASE_PULSE_EN
    .release_pulse (release_pulse),
`endif
    .press_pulse   (press_pulse),
    .held          (held)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    pin_in = 3'b000;
    repeat (2) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pin_in = 3'b000;
    repeat_en = 3'b111;
    repeat (2) step();
    checks++;
    if (press_pulse !== 3'b000 || held !== 3'b000) begin
      errors++;
      $display("FAIL reset: pulse=%b held=%b want 000/000", press_pulse, held);
    end
    rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if (press_pulse !== 3'b000 || held !== 3'b000) begin
      errors++;
      $display("FAIL post_reset: pulse=%b held=%b want 000/000", press_pulse, held);
    end
  endtask

  task automatic test_repeat();
    logic [31:0] seen;
    logic        held_bad;
    logic        other;
    seen = '0;
    held_bad = 1'b0;
    other = 1'b0;
    repeat_en = 3'b111;
    pin_in = 3'b001;
    for (int k = 1; k <= 30; k++) begin
      step();
      seen[k] = press_pulse[0];
      if (held[0] !== 1'b1) held_bad = 1'b1;
      if (press_pulse[2:1] !== 2'b00) other = 1'b1;
    end
    checks++;
    if (seen !== 32'h0888_8802) begin
      errors++;
      $display("FAIL repeat_pattern: got %h want %h", seen, 32'h0888_8802);
    end
    checks++;
    if (held_bad !== 1'b0) begin
      errors++;
      $display("FAIL repeat_held: held[0] dropped during hold");
    end
    checks++;
    if (other !== 1'b0) begin
      errors++;
      $display("FAIL repeat_isolation: other pins pulsed");
    end
    // step 31 is a repeat terminal count; the release must win
    pin_in = 3'b000;
    step();
    checks++;
    if (press_pulse !== 3'b000 || held !== 3'b000) begin
      errors++;
      $display("FAIL repeat_release: pulse=%b held=%b want 000/000", press_pulse, held);
    end
    idle_all();
  endtask

  task automatic test_no_repeat();
    logic [31:0] seen;
    seen = '0;
    repeat_en = 3'b110;
    pin_in = 3'b001;
    for (int k = 1; k <= 20; k++) begin
      step();
      seen[k] = press_pulse[0];
    end
    checks++;
    if (seen !== 32'h0000_0002) begin
      errors++;
      $display("FAIL norep_pattern: got %h want %h", seen, 32'h2);
    end
    repeat_en = 3'b111;
    step();
    checks++;
    if (press_pulse[0] !== 1'b1) begin
      errors++;
      $display("FAIL norep_enable: pulse=%b want 1", press_pulse[0]);
    end
    seen = '0;
    for (int k = 22; k <= 25; k++) begin
      step();
      seen[k] = press_pulse[0];
    end
    checks++;
    if (seen !== 32'h0200_0000) begin
      errors++;
      $display("FAIL norep_followup: got %h want %h", seen, 32'h0200_0000);
    end
    idle_all();
  endtask

  task automatic test_terminal_release();
    logic [31:0] seen;
    repeat_en = 3'b111;
    pin_in = 3'b001;
    repeat (9) step();
    pin_in = 3'b000;
    step();
    checks++;
    if (press_pulse[0] !== 1'b0 || held[0] !== 1'b0) begin
      errors++;
      $display("FAIL term_release: pulse=%b held=%b want 0/0", press_pulse[0], held[0]);
    end
    step();
    seen = '0;
    pin_in = 3'b001;
    for (int k = 1; k <= 11; k++) begin
      step();
      seen[k] = press_pulse[0];
    end
    checks++;
    if (seen !== 32'h0000_0802) begin
      errors++;
      $display("FAIL term_restart: got %h want %h", seen, 32'h802);
    end
    idle_all();
  endtask

  task automatic test_multi();
    repeat_en = 3'b111;
    pin_in = 3'b011;
    step();
    checks++;
    if (press_pulse !== 3'b011 || held !== 3'b011) begin
      errors++;
      $display("FAIL multi_press: pulse=%b held=%b want 011/011", press_pulse, held);
    end
    step();
    checks++;
    if (press_pulse !== 3'b000) begin
      errors++;
      $display("FAIL multi_width: pulse=%b want 000", press_pulse);
    end
    idle_all();
  endtask

  task automatic test_held_through_reset();
    logic any;
    any = 1'b0;
    rst_n = 1'b0;
    pin_in = 3'b111;
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (press_pulse !== 3'b000 || held !== 3'b000) any = 1'b1;
    end
    checks++;
    if (any !== 1'b0) begin
      errors++;
      $display("FAIL held_reset: events seen while held through reset");
    end
    pin_in = 3'b000;
    step();
`ifdef BTN_RELEASE_PULSE_EN
    checks++;
    if (release_pulse !== 3'b000) begin
      errors++;
      $display("FAIL held_reset_rel: release=%b want 000", release_pulse);
    end
`endif
    step();
    pin_in = 3'b100;
    step();
    checks++;
    if (press_pulse !== 3'b100) begin
      errors++;
      $display("FAIL held_reset_press: pulse=%b want 100", press_pulse);
    end
    idle_all();
  endtask

  task automatic test_reset_mid_count();
    logic any;
    any = 1'b0;
    repeat_en = 3'b111;
    pin_in = 3'b001;
    repeat (13) step();
    checks++;
    if (held[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: held=%b want 1", held[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (press_pulse !== 3'b000 || held !== 3'b000) begin
      errors++;
      $display("FAIL midrst_async: pulse=%b held=%b want 000/000", press_pulse, held);
    end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (press_pulse !== 3'b000 || held !== 3'b000) any = 1'b1;
    end
    checks++;
    if (any !== 1'b0) begin
      errors++;
      $display("FAIL midrst_quiet: events after reset while held");
    end
    pin_in = 3'b000;
    step();
    pin_in = 3'b001;
    step();
    checks++;
    if (press_pulse !== 3'b001) begin
      errors++;
      $display("FAIL midrst_repress: pulse=%b want 001", press_pulse);
    end
    idle_all();
  endtask

`ifdef BTN_RELEASE_PULSE_EN
  task automatic test_release();
    repeat_en = 3'b111;
    pin_in = 3'b001;
    repeat (5) step();
    checks++;
    if (release_pulse !== 3'b000) begin
      errors++;
      $display("FAIL rel_early: release=%b want 000", release_pulse);
    end
    pin_in = 3'b000;
    step();
    checks++;
    if (release_pulse !== 3'b001) begin
      errors++;
      $display("FAIL rel_pulse: release=%b want 001", release_pulse);
    end
    step();
    checks++;
    if (release_pulse !== 3'b000) begin
      errors++;
      $display("FAIL rel_width: release=%b want 000", release_pulse);
    end
    idle_all();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    pin_in = 3'b000;
    repeat_en = 3'b111;
    test_reset();
    test_repeat();
    test_no_repeat();
    test_terminal_release();
    test_multi();
    test_held_through_reset();
    test_reset_mid_count();
`ifdef BTN_RELEASE_PULSE_EN
    test_release();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
